// File: rtl/cp0_pkg.sv
// cp0_pkg: definitions shared between the exception controller and the CP0 register file.
//   - Cause.ExcCode values
//   - exception FSM state encoding
//   - default exception vector
//   - CP0 register numbers
package cp0_pkg;

   // Cause.ExcCode values
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Boot-time exception vector (BEV=1)
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

   // CP0 register numbers
   localparam logic [4:0] BADVADDR = 5'd8;
   localparam logic [4:0] STATUS   = 5'd12;
   localparam logic [4:0] CAUSE    = 5'd13;
   localparam logic [4:0] EPC      = 5'd14;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StFlush    = 2'd1,
      StRedirect = 2'd2
   } exc_state_e;

endpackage

// File: rtl/int_sync.sv
// int_sync: two-flop synchroniser for asynchronous interrupt lines.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset (clears both stages)
//   async_i asynchronous input lines
//   sync_o  synchronised lines (2-cycle latency)
module int_sync #(
   parameter int unsigned Width = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] async_i,
   output logic [Width-1:0] sync_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt controller sitting between MEM and CP0.
// Selects the highest-priority event at commit, emits the CP0 update bundle
// (EPC, ExcCode, BD, BadVAddr, EXL set/clear), then flushes the pipeline and
// redirects IF to the exception vector (or EPC for ERET) via valid/ready.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_*                  MEM-stage instruction: valid, pc, delay-slot, bad data address, ERET
//   exc_*                  per-instruction exception flags
//   hw_int, sw_int         interrupt sources (hw_int asynchronous)
//   status_im/exl/ie       Status fields; cp0_epc is the ERET target
//   cp0_*                  CP0 write strobes and data
//   ip_pending             {synchronised hw_int, sw_int} for Cause.IP
//   flush                  kill IF..MEM
//   redirect_valid/ready   redirect handshake with IF, target on redirect_pc
//   busy                   FSM not idle; stalls commit
module exc_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic        exc_if_adel,
   input  logic        exc_ri,
   input  logic        exc_ov,
   input  logic        exc_sys,
   input  logic        exc_bp,
   input  logic        exc_adel,
   input  logic        exc_ades,
   input  logic [31:0] mem_badaddr,
   input  logic        mem_eret,
   input  logic [5:0]  hw_int,
   input  logic [1:0]  sw_int,
   input  logic [7:0]  status_im,
   input  logic        status_exl,
   input  logic        status_ie,
   input  logic [31:0] cp0_epc,
   input  logic        redirect_ready,
   output logic        cp0_exc_we,
   output logic [4:0]  cp0_exc_code,
   output logic [31:0] cp0_epc_out,
   output logic        cp0_bd,
   output logic        cp0_badv_we,
   output logic [31:0] cp0_badvaddr,
   output logic        cp0_clr_exl,
   output logic [7:0]  ip_pending,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   // Counter loads N-1 so flush stays high for exactly FLUSH_CYCLES cycles.
   localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

   logic [5:0] hw_sync;
   logic       int_take;
   logic       exc_take;
   logic [4:0] code_sel;
   logic       badv_sel;
   logic [31:0] badv_val;

   exc_state_e  state_q;
   logic [3:0]  cnt_q;
   logic        exc_we_q;
   logic [4:0]  code_q;
   logic [31:0] epc_q;
   logic        bd_q;
   logic        badv_we_q;
   logic [31:0] badvaddr_q;
   logic        clr_exl_q;
   logic        flush_q;
   logic        rv_q;
   logic [31:0] rpc_q;

   int_sync #(
      .Width (6)
   ) u_int_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (hw_int),
      .sync_o  (hw_sync)
   );

   assign ip_pending = {hw_sync, sw_int};
   assign int_take   = status_ie && !status_exl && (|(ip_pending & status_im));

   // Fixed-priority encoder; interrupts win over every synchronous exception.
   always_comb begin
      exc_take = 1'b1;
      code_sel = EXC_INT;
      badv_sel = 1'b0;
      badv_val = mem_badaddr;
      if (int_take) begin
         code_sel = EXC_INT;
      end else if (exc_if_adel) begin
         code_sel = EXC_ADEL;
         badv_sel = 1'b1;
         badv_val = mem_pc;
      end else if (exc_ri) begin
         code_sel = EXC_RI;
      end else if (exc_ov) begin
         code_sel = EXC_OV;
      end else if (exc_sys) begin
         code_sel = EXC_SYS;
      end else if (exc_bp) begin
         code_sel = EXC_BP;
      end else if (exc_adel) begin
         code_sel = EXC_ADEL;
         badv_sel = 1'b1;
      end else if (exc_ades) begin
         code_sel = EXC_ADES;
         badv_sel = 1'b1;
      end else begin
         exc_take = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         exc_we_q   <= 1'b0;
         code_q     <= '0;
         epc_q      <= '0;
         bd_q       <= 1'b0;
         badv_we_q  <= 1'b0;
         badvaddr_q <= '0;
         clr_exl_q  <= 1'b0;
         flush_q    <= 1'b0;
         rv_q       <= 1'b0;
         rpc_q      <= '0;
      end else begin
         // Strobes default low; data registers hold their last value.
         exc_we_q  <= 1'b0;
         badv_we_q <= 1'b0;
         clr_exl_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (mem_valid && (exc_take || mem_eret)) begin
                  state_q <= StFlush;
                  flush_q <= 1'b1;
                  cnt_q   <= FlushInit;
                  if (exc_take) begin
                     exc_we_q  <= 1'b1;
                     code_q    <= code_sel;
                     epc_q     <= mem_bd ? (mem_pc - 32'd4) : mem_pc;
                     bd_q      <= mem_bd;
                     badv_we_q <= badv_sel;
                     if (badv_sel) begin
                        badvaddr_q <= badv_val;
                     end
                     rpc_q <= EXC_VECTOR;
                  end else begin
                     clr_exl_q <= 1'b1;
                     rpc_q     <= cp0_epc;
                  end
               end
            end
            StFlush: begin
               if (cnt_q == 4'd0) begin
                  flush_q <= 1'b0;
                  rv_q    <= 1'b1;
                  state_q <= StRedirect;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StRedirect: begin
               if (redirect_ready) begin
                  rv_q    <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               flush_q <= 1'b0;
               rv_q    <= 1'b0;
            end
         endcase
      end
   end

   assign cp0_exc_we     = exc_we_q;
   assign cp0_exc_code   = code_q;
   assign cp0_epc_out    = epc_q;
   assign cp0_bd         = bd_q;
   assign cp0_badv_we    = badv_we_q;
   assign cp0_badvaddr   = badvaddr_q;
   assign cp0_clr_exl    = clr_exl_q;
   assign flush          = flush_q;
   assign redirect_valid = rv_q;
   assign redirect_pc    = rpc_q;
   assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: reset state, priority encoding, CP0 bundle,
// flush/redirect sequencing, handshake stall and reset during flush.
module tb_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_bd;
   logic        exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades;
   logic [31:0] mem_badaddr;
   logic        mem_eret;
   logic [5:0]  hw_int;
   logic [1:0]  sw_int;
   logic [7:0]  status_im;
   logic        status_exl;
   logic        status_ie;
   logic [31:0] cp0_epc;
   logic        redirect_ready;
   logic        cp0_exc_we;
   logic [4:0]  cp0_exc_code;
   logic [31:0] cp0_epc_out;
   logic        cp0_bd;
   logic        cp0_badv_we;
   logic [31:0] cp0_badvaddr;
   logic        cp0_clr_exl;
   logic [7:0]  ip_pending;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;

   int n_vec  = 0;
   int n_miss = 0;

   exc_ctrl u_dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid      (mem_valid),
      .mem_pc         (mem_pc),
      .mem_bd         (mem_bd),
      .exc_if_adel    (exc_if_adel),
      .exc_ri         (exc_ri),
      .exc_ov         (exc_ov),
      .exc_sys        (exc_sys),
      .exc_bp         (exc_bp),
      .exc_adel       (exc_adel),
      .exc_ades       (exc_ades),
      .mem_badaddr    (mem_badaddr),
      .mem_eret       (mem_eret),
      .hw_int         (hw_int),
      .sw_int         (sw_int),
      .status_im      (status_im),
      .status_exl     (status_exl),
      .status_ie      (status_ie),
      .cp0_epc        (cp0_epc),
      .redirect_ready (redirect_ready),
      .cp0_exc_we     (cp0_exc_we),
      .cp0_exc_code   (cp0_exc_code),
      .cp0_epc_out    (cp0_epc_out),
      .cp0_bd         (cp0_bd),
      .cp0_badv_we    (cp0_badv_we),
      .cp0_badvaddr   (cp0_badvaddr),
      .cp0_clr_exl    (cp0_clr_exl),
      .ip_pending     (ip_pending),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // flags = {if_adel, ri, ov, sys, bp, adel, ades}; returns just after edge T.
   task automatic commit(input logic [6:0] flags, input logic eret, input logic [31:0] pc,
                         input logic bd, input logic [31:0] badaddr);
      mem_valid   = 1'b1;
      {exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades} = flags;
      mem_eret    = eret;
      mem_pc      = pc;
      mem_bd      = bd;
      mem_badaddr = badaddr;
      step();
      mem_valid = 1'b0;
      {exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades} = '0;
      mem_eret  = 1'b0;
      mem_bd    = 1'b0;
   endtask

   // From T+1: two flush edges land in REDIRECT, ready then returns to IDLE.
   task automatic drain(input string tag);
      redirect_ready = 1'b1;
      repeat (3) step();
      check(tag, {31'd0, busy}, 32'd0);
      redirect_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0; mem_badaddr = '0; mem_eret = 1'b0;
      {exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel, exc_ades} = '0;
      hw_int = '0; sw_int = '0; status_im = '0; status_exl = 1'b0; status_ie = 1'b0;
      cp0_epc = '0; redirect_ready = 1'b0;
      repeat (3) step();
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
      check("rst_we",    {31'd0, cp0_exc_we}, 32'd0);
      check("rst_rpc",   redirect_pc, 32'd0);
      check("rst_ip",    {24'd0, ip_pending}, 32'd0);
      rst = 1'b0;
      step();

      // Overflow, not in a delay slot
      commit(7'b0010000, 1'b0, 32'h8000_1000, 1'b0, 32'h0);
      check("ov_we",    {31'd0, cp0_exc_we}, 32'd1);
      check("ov_code",  {27'd0, cp0_exc_code}, 32'd12);
      check("ov_epc",   cp0_epc_out, 32'h8000_1000);
      check("ov_bd",    {31'd0, cp0_bd}, 32'd0);
      check("ov_bvwe",  {31'd0, cp0_badv_we}, 32'd0);
      check("ov_fl1",   {31'd0, flush}, 32'd1);
      check("ov_busy",  {31'd0, busy}, 32'd1);
      check("ov_rv1",   {31'd0, redirect_valid}, 32'd0);
      step();
      check("ov_we_off", {31'd0, cp0_exc_we}, 32'd0);
      check("ov_fl2",   {31'd0, flush}, 32'd1);
      check("ov_rv2",   {31'd0, redirect_valid}, 32'd0);
      step();
      check("ov_fl3",   {31'd0, flush}, 32'd0);
      check("ov_rv3",   {31'd0, redirect_valid}, 32'd1);
      check("ov_rpc",   redirect_pc, 32'hBFC0_0380);
      redirect_ready = 1'b1;
      step();
      check("ov_rv4",   {31'd0, redirect_valid}, 32'd0);
      check("ov_idle",  {31'd0, busy}, 32'd0);
      redirect_ready = 1'b0;

      // Load AdEL in a delay slot
      commit(7'b0000010, 1'b0, 32'h8000_2004, 1'b1, 32'h0000_0003);
      check("adel_code", {27'd0, cp0_exc_code}, 32'd4);
      check("adel_epc",  cp0_epc_out, 32'h8000_2000);
      check("adel_bd",   {31'd0, cp0_bd}, 32'd1);
      check("adel_bvwe", {31'd0, cp0_badv_we}, 32'd1);
      check("adel_bva",  cp0_badvaddr, 32'h0000_0003);
      step();
      check("adel_bvwe_off", {31'd0, cp0_badv_we}, 32'd0);
      redirect_ready = 1'b1;
      repeat (2) step();
      check("adel_idle", {31'd0, busy}, 32'd0);
      redirect_ready = 1'b0;

      // IF AdEL beats RI and AdES; BadVAddr takes the PC
      commit(7'b1100001, 1'b0, 32'h8000_6000, 1'b0, 32'h1234_5678);
      check("ifadel_code", {27'd0, cp0_exc_code}, 32'd4);
      check("ifadel_bva",  cp0_badvaddr, 32'h8000_6000);
      drain("ifadel_drain");

      // Ov beats Sys
      commit(7'b0011000, 1'b0, 32'h8000_6100, 1'b0, 32'h0);
      check("ovsys_code", {27'd0, cp0_exc_code}, 32'd12);
      drain("ovsys_drain");

      // AdES alone
      commit(7'b0000001, 1'b0, 32'h8000_6200, 1'b0, 32'hDEAD_BEE0);
      check("ades_code", {27'd0, cp0_exc_code}, 32'd5);
      check("ades_bva",  cp0_badvaddr, 32'hDEAD_BEE0);
      drain("ades_drain");

      // Exception beats ERET
      commit(7'b0000100, 1'b1, 32'h8000_6300, 1'b0, 32'h0);
      check("bperet_code", {27'd0, cp0_exc_code}, 32'd9);
      check("bperet_clr",  {31'd0, cp0_clr_exl}, 32'd0);
      drain("bperet_drain");

      // Interrupt via hw_int[2] -> ip_pending[4], after sync latency
      status_ie = 1'b1; status_exl = 1'b0; status_im = 8'h10;
      hw_int = 6'b000100;
      step();
      check("ip_lat1", {24'd0, ip_pending}, 32'h00);
      step();
      check("ip_lat2", {24'd0, ip_pending}, 32'h10);
      commit(7'b0001000, 1'b0, 32'h8000_4000, 1'b0, 32'h0);
      check("int_we",   {31'd0, cp0_exc_we}, 32'd1);
      check("int_code", {27'd0, cp0_exc_code}, 32'd0);
      check("int_epc",  cp0_epc_out, 32'h8000_4000);
      check("int_bvwe", {31'd0, cp0_badv_we}, 32'd0);
      drain("int_drain");

      // Same with EXL set: interrupt masked, syscall taken
      status_exl = 1'b1;
      commit(7'b0001000, 1'b0, 32'h8000_4100, 1'b0, 32'h0);
      check("exl_code", {27'd0, cp0_exc_code}, 32'd8);
      drain("exl_drain");
      hw_int = '0; status_ie = 1'b0; status_exl = 1'b0; status_im = '0;
      repeat (2) step();

      // ERET with EXL already clear
      cp0_epc = 32'h8000_3010;
      commit(7'b0000000, 1'b1, 32'h8000_5000, 1'b0, 32'h0);
      check("eret_clr",  {31'd0, cp0_clr_exl}, 32'd1);
      check("eret_we",   {31'd0, cp0_exc_we}, 32'd0);
      check("eret_fl",   {31'd0, flush}, 32'd1);
      step();
      check("eret_clr_off", {31'd0, cp0_clr_exl}, 32'd0);
      step();
      check("eret_rv",   {31'd0, redirect_valid}, 32'd1);
      check("eret_rpc",  redirect_pc, 32'h8000_3010);
      redirect_ready = 1'b1;
      step();
      check("eret_idle", {31'd0, busy}, 32'd0);
      redirect_ready = 1'b0;

      // Handshake stall with a second commit attempt while busy
      commit(7'b0100000, 1'b0, 32'h8000_7000, 1'b0, 32'h0);
      check("ri_code", {27'd0, cp0_exc_code}, 32'd10);
      repeat (2) step();
      mem_valid = 1'b1; exc_bp = 1'b1; mem_pc = 32'h8000_7100;
      for (int i = 0; i < 5; i++) begin
         check("stall_rv",   {31'd0, redirect_valid}, 32'd1);
         check("stall_rpc",  redirect_pc, 32'hBFC0_0380);
         check("stall_busy", {31'd0, busy}, 32'd1);
         check("stall_we",   {31'd0, cp0_exc_we}, 32'd0);
         step();
      end
      mem_valid = 1'b0; exc_bp = 1'b0;
      redirect_ready = 1'b1;
      step();
      check("stall_rv_off", {31'd0, redirect_valid}, 32'd0);
      check("stall_idle",   {31'd0, busy}, 32'd0);
      redirect_ready = 1'b0;
      step();
      check("stall_code", {27'd0, cp0_exc_code}, 32'd10);
      check("stall_we2",  {31'd0, cp0_exc_we}, 32'd0);

      // Reset in flush cycle 1
      commit(7'b0010000, 1'b0, 32'h8000_8000, 1'b0, 32'h0);
      check("rstfl_fl", {31'd0, flush}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstfl_fl0",   {31'd0, flush}, 32'd0);
      check("rstfl_busy",  {31'd0, busy}, 32'd0);
      check("rstfl_rv",    {31'd0, redirect_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rstfl_norv", {31'd0, redirect_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
